// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller.
//   fetch_state_e : sequencing states of the fetch FSM (2-bit encoding)
//   PC_W          : width of program-counter and instruction-memory addresses
//   is_word_aligned() : true when an address is aligned to a 32-bit word
package fetch_ctrl_pkg;

    localparam int unsigned PC_W = 32;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_FETCH = 2'd1,
        FS_FAULT = 2'd2
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [PC_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller. Reads instruction memory at the current PC,
// captures the word into the IF/ID register and either advances the external
// program counter or redirects it on a taken branch. Decode back-pressures
// the fetch through STALL.
//
// Ports:
//   CLK, RST          clock and synchronous active-high reset
//   PC_OUT            current PC from the external program_counter
//   PC_IN, W_PC       next PC and its write enable (combinational)
//   IMEM_ADDR/REQ     instruction read address (= PC_OUT) and request
//   IMEM_ACK/DATA     read response; ignored while IMEM_REQ is low
//   BR_TAKEN/TARGET   redirect request from execute
//   STALL             decode cannot accept IR this cycle
//   IR, IR_PC         registered instruction and its PC
//   IR_VALID          IR holds a valid instruction
//   FAULT             sticky misaligned-branch fault
//   FETCH_CNT         instructions accepted into IR since reset (wraps)
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0]  RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned  PC_INC       = 4,
    parameter int unsigned  CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      PC_OUT,
    output logic [31:0]      PC_IN,
    output logic             W_PC,
    output logic [31:0]      IMEM_ADDR,
    output logic             IMEM_REQ,
    input  logic             IMEM_ACK,
    input  logic [31:0]      IMEM_DATA,
    input  logic             BR_TAKEN,
    input  logic [31:0]      BR_TARGET,
    input  logic             STALL,
    output logic [31:0]      IR,
    output logic [31:0]      IR_PC,
    output logic             IR_VALID,
    output logic             FAULT,
    output logic [CNT_W-1:0] FETCH_CNT
);

    fetch_state_e     state_q, state_d;

    logic [31:0]      ir_q, ir_d;
    logic [31:0]      ir_pc_q, ir_pc_d;
    logic             ir_valid_q, ir_valid_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             slot_free;
    logic             br_aligned;
    logic             accept;
    logic             imem_req;

    assign IMEM_ADDR = PC_OUT;
    assign IMEM_REQ  = imem_req;
    assign IR        = ir_q;
    assign IR_PC     = ir_pc_q;
    assign IR_VALID  = ir_valid_q;
    assign FAULT     = fault_q;
    assign FETCH_CNT = cnt_q;

    always_comb begin
        slot_free  = !ir_valid_q || !STALL;
        br_aligned = is_word_aligned(BR_TARGET);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FS_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_BOOT:  state_d = FS_FETCH;
            FS_FETCH: begin
                if (BR_TAKEN && !br_aligned) begin
                    state_d = FS_FAULT;
                end
            end
            FS_FAULT: state_d = FS_FAULT;
            default:  state_d = FS_BOOT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Reset forces the PC write and read request low even though state_q
    // already reads BOOT after the first reset edge.
    always_comb begin
        W_PC     = 1'b0;
        PC_IN    = '0;
        imem_req = 1'b0;
        accept   = 1'b0;
        if (!RST) begin
            case (state_q)
                FS_BOOT: begin
                    W_PC  = 1'b1;
                    PC_IN = RESET_VECTOR;
                end
                FS_FETCH: begin
                    imem_req = slot_free && !BR_TAKEN;
                    if (BR_TAKEN) begin
                        if (br_aligned) begin
                            W_PC  = 1'b1;
                            PC_IN = BR_TARGET;
                        end
                    end else if (imem_req && IMEM_ACK) begin
                        accept = 1'b1;
                        W_PC   = 1'b1;
                        PC_IN  = PC_OUT + 32'(PC_INC);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- IF/ID register, fault flag and counter ----------------
    always_comb begin
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
        case (state_q)
            FS_FETCH: begin
                if (BR_TAKEN) begin
                    // Flush regardless of STALL; a same-cycle ACK is dropped.
                    ir_valid_d = 1'b0;
                    if (!br_aligned) begin
                        fault_d = 1'b1;
                    end
                end else if (accept) begin
                    ir_d       = IMEM_DATA;
                    ir_pc_d    = PC_OUT;
                    ir_valid_d = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                end else if (ir_valid_q && !STALL) begin
                    ir_valid_d = 1'b0;
                end
            end
            FS_FAULT: begin
                ir_valid_d = 1'b0;
                fault_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: an open-loop vector table with PC_OUT driven
// directly, then closed-loop sequences through a behavioural program counter.
// A second instance with a 2-bit counter exercises FETCH_CNT wrap.
module tb_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] pc_out;
    logic [31:0] pc_drv;
    logic [31:0] pc_reg;
    logic        pc_model_en;
    logic        ack;
    logic [31:0] data;
    logic        br;
    logic [31:0] tgt;
    logic        stall;

    logic [31:0] pc_in, imem_addr, ir, ir_pc;
    logic        w_pc, imem_req, ir_valid, fault;
    logic [15:0] cnt;

    logic [31:0] pc_in2, imem_addr2, ir2, ir_pc2;
    logic        w_pc2, imem_req2, ir_valid2, fault2;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    assign pc_out = pc_model_en ? pc_reg : pc_drv;

    // Behavioural program_counter used by the closed-loop sequences.
    always @(posedge CLK) begin
        if (!pc_model_en)  pc_reg <= 32'h0;
        else if (w_pc)     pc_reg <= pc_in;
    end

    fetch_ctrl #(.RESET_VECTOR(32'h100), .PC_INC(4), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .PC_OUT(pc_out), .PC_IN(pc_in), .W_PC(w_pc),
        .IMEM_ADDR(imem_addr), .IMEM_REQ(imem_req), .IMEM_ACK(ack),
        .IMEM_DATA(data), .BR_TAKEN(br), .BR_TARGET(tgt), .STALL(stall),
        .IR(ir), .IR_PC(ir_pc), .IR_VALID(ir_valid), .FAULT(fault),
        .FETCH_CNT(cnt)
    );

    fetch_ctrl #(.RESET_VECTOR(32'h100), .PC_INC(4), .CNT_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .PC_OUT(pc_out), .PC_IN(pc_in2), .W_PC(w_pc2),
        .IMEM_ADDR(imem_addr2), .IMEM_REQ(imem_req2), .IMEM_ACK(ack),
        .IMEM_DATA(data), .BR_TAKEN(br), .BR_TARGET(tgt), .STALL(stall),
        .IR(ir2), .IR_PC(ir_pc2), .IR_VALID(ir_valid2), .FAULT(fault2),
        .FETCH_CNT(cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        ack;
        logic [31:0] data;
        logic        br;
        logic [31:0] tgt;
        logic        stall;
        logic        e_wpc;
        logic [31:0] e_pcin;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_ir;
        logic [31:0] e_irpc;
        logic        e_fault;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic r, logic [31:0] p, logic a, logic [31:0] d, logic b, logic [31:0] t, logic s,
        logic ew, logic [31:0] epi, logic erq, logic ev, logic [31:0] eir,
        logic [31:0] eirpc, logic ef, logic [15:0] ec);
        vec_t v;
        v.rst = r;  v.pc = p;  v.ack = a;  v.data = d;  v.br = b;  v.tgt = t;  v.stall = s;
        v.e_wpc = ew;  v.e_pcin = epi;  v.e_req = erq;  v.e_valid = ev;
        v.e_ir = eir;  v.e_irpc = eirpc;  v.e_fault = ef;  v.e_cnt = ec;
        return v;
    endfunction

    localparam logic [31:0] A0 = 32'hA000_0000;
    localparam logic [31:0] A1 = 32'hA000_0001;
    localparam logic [31:0] A2 = 32'hA000_0002;
    localparam logic [31:0] BW = 32'hBBBB_0000;
    localparam logic [31:0] C0 = 32'hC000_0000;
    localparam logic [31:0] DW = 32'hDDDD_0000;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst pc            ack data br tgt        st | wpc pcin          req | v  ir  irpc          f  cnt
        vecs.push_back(mk(1, 32'h0,        0, 0,  0, 32'h0,   0,  0, 32'h0,   0,  0, 32'h0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 32'h0,        1, A0, 1, 32'h200, 0,  0, 32'h0,   0,  0, 32'h0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 32'h0,        0, 0,  0, 32'h0,   0,  1, 32'h100, 0,  0, 32'h0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 32'h100,      1, A0, 0, 32'h0,   0,  1, 32'h104, 1,  1, A0,    32'h100,      0, 1));
        vecs.push_back(mk(0, 32'h104,      1, A1, 0, 32'h0,   0,  1, 32'h108, 1,  1, A1,    32'h104,      0, 2));
        vecs.push_back(mk(0, 32'h108,      1, A2, 0, 32'h0,   0,  1, 32'h10C, 1,  1, A2,    32'h108,      0, 3));
        vecs.push_back(mk(0, 32'h10C,      1, BW, 0, 32'h0,   1,  0, 32'h0,   0,  1, A2,    32'h108,      0, 3));
        vecs.push_back(mk(0, 32'h10C,      0, BW, 0, 32'h0,   0,  0, 32'h0,   1,  0, A2,    32'h108,      0, 3));
        vecs.push_back(mk(0, 32'h10C,      1, BW, 1, 32'h200, 0,  1, 32'h200, 0,  0, A2,    32'h108,      0, 3));
        vecs.push_back(mk(0, 32'h200,      1, C0, 0, 32'h0,   0,  1, 32'h204, 1,  1, C0,    32'h200,      0, 4));
        vecs.push_back(mk(0, 32'hFFFF_FFFC,1, DW, 0, 32'h0,   0,  1, 32'h0,   1,  1, DW,    32'hFFFF_FFFC,0, 5));
        vecs.push_back(mk(0, 32'h0,        1, A0, 1, 32'h202, 0,  0, 32'h0,   0,  0, DW,    32'hFFFF_FFFC,1, 5));
        vecs.push_back(mk(0, 32'h0,        1, A0, 1, 32'h300, 0,  0, 32'h0,   0,  0, DW,    32'hFFFF_FFFC,1, 5));
        vecs.push_back(mk(1, 32'h0,        1, A0, 1, 32'h300, 0,  0, 32'h0,   0,  0, 32'h0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 32'h0,        0, 0,  0, 32'h0,   0,  1, 32'h100, 0,  0, 32'h0, 32'h0,        0, 0));

        pc_model_en = 1'b0;
        RST = 1'b1; pc_drv = '0; ack = 1'b0; data = '0; br = 1'b0; tgt = '0; stall = 1'b0;
        @(posedge CLK); #1;

        // ---------------- open-loop vector table ----------------
        foreach (vecs[i]) begin
            RST = vecs[i].rst;  pc_drv = vecs[i].pc;  ack = vecs[i].ack;  data = vecs[i].data;
            br  = vecs[i].br;   tgt    = vecs[i].tgt; stall = vecs[i].stall;
            #1;
            chk($sformatf("v%0d_w_pc", i),      32'(w_pc),     32'(vecs[i].e_wpc));
            chk($sformatf("v%0d_pc_in", i),     pc_in,         vecs[i].e_pcin);
            chk($sformatf("v%0d_imem_req", i),  32'(imem_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_imem_addr", i), imem_addr,     vecs[i].pc);
            @(posedge CLK); #1;
            chk($sformatf("v%0d_ir_valid", i),  32'(ir_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_ir", i),        ir,            vecs[i].e_ir);
            chk($sformatf("v%0d_ir_pc", i),     ir_pc,         vecs[i].e_irpc);
            chk($sformatf("v%0d_fault", i),     32'(fault),    32'(vecs[i].e_fault));
            chk($sformatf("v%0d_cnt", i),       32'(cnt),      32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_cnt2", i),      32'(cnt2),     32'(vecs[i].e_cnt[1:0]));
        end

        // ---------------- closed loop: reset and boot ----------------
        pc_model_en = 1'b1;
        RST = 1'b1; ack = 1'b0; data = '0; br = 1'b0; tgt = '0; stall = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        chk("boot_w_pc",     32'(w_pc),     32'd1);
        chk("boot_pc_in",    pc_in,         32'h100);
        chk("boot_req",      32'(imem_req), 32'd0);
        chk("boot_valid",    32'(ir_valid), 32'd0);
        @(posedge CLK); #1;
        chk("first_req",     32'(imem_req), 32'd1);
        chk("first_addr",    imem_addr,     32'h100);
        chk("first_valid",   32'(ir_valid), 32'd0);

        // ---------------- capture A0 then stall 3 cycles ----------------
        ack = 1'b1; data = A0;
        #1;
        chk("a0_w_pc",       32'(w_pc),     32'd1);
        chk("a0_pc_in",      pc_in,         32'h104);
        @(posedge CLK); #1;
        chk("a0_ir",         ir,            A0);
        chk("a0_ir_pc",      ir_pc,         32'h100);
        stall = 1'b1; data = A1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_req", k),   32'(imem_req), 32'd0);
            chk($sformatf("stall%0d_w_pc", k),  32'(w_pc),     32'd0);
            chk($sformatf("stall%0d_ir", k),    ir,            A0);
            chk($sformatf("stall%0d_ir_pc", k), ir_pc,         32'h100);
            chk($sformatf("stall%0d_pc", k),    pc_out,        32'h104);
            @(posedge CLK); #1;
        end
        stall = 1'b0;
        #1;
        chk("resume_req",    32'(imem_req), 32'd1);
        chk("resume_addr",   imem_addr,     32'h104);
        chk("resume_w_pc",   32'(w_pc),     32'd1);
        @(posedge CLK); #1;
        chk("a1_ir",         ir,            A1);
        chk("a1_ir_pc",      ir_pc,         32'h104);
        chk("a1_cnt",        32'(cnt),      32'd2);

        // ---------------- branch with ACK and STALL ----------------
        stall = 1'b1; br = 1'b1; tgt = 32'h200; data = BW;
        #1;
        chk("br_w_pc",       32'(w_pc),     32'd1);
        chk("br_pc_in",      pc_in,         32'h200);
        chk("br_req",        32'(imem_req), 32'd0);
        @(posedge CLK); #1;
        chk("br_valid",      32'(ir_valid), 32'd0);
        chk("br_cnt",        32'(cnt),      32'd2);
        chk("br_pc",         pc_out,        32'h200);
        br = 1'b0; stall = 1'b0; ack = 1'b0;
        #1;
        chk("br_next_req",   32'(imem_req), 32'd1);
        chk("br_next_addr",  imem_addr,     32'h200);

        // ---------------- misaligned branch -> sticky fault ----------------
        br = 1'b1; tgt = 32'h202; ack = 1'b1;
        #1;
        chk("mis_w_pc",      32'(w_pc),     32'd0);
        chk("mis_pc_in",     pc_in,         32'h0);
        @(posedge CLK); #1;
        for (int k = 0; k < 5; k++) begin
            br = k[0]; tgt = 32'h300; ack = 1'b1; stall = k[1];
            #1;
            chk($sformatf("fault%0d_fault", k), 32'(fault),    32'd1);
            chk($sformatf("fault%0d_req", k),   32'(imem_req), 32'd0);
            chk($sformatf("fault%0d_w_pc", k),  32'(w_pc),     32'd0);
            chk($sformatf("fault%0d_valid", k), 32'(ir_valid), 32'd0);
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; br = 1'b0; ack = 1'b0; stall = 1'b0;
        #1;
        chk("rec_fault",     32'(fault),    32'd0);
        chk("rec_w_pc",      32'(w_pc),     32'd1);
        chk("rec_pc_in",     pc_in,         32'h100);
        @(posedge CLK); #1;
        chk("rec_pc",        pc_out,        32'h100);
        chk("rec_req",       32'(imem_req), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
